// File: rtl/keypad_entry_if.sv
// -----------------------------------------------------------------------------
// keypad_entry_if
//
// Groups the keypad pins and the entry/commit result bus of keypad_entry.
//
// Signals:
//   row        [3:0]  keypad rows, active-low (keypad -> entry block)
//   col        [3:0]  column drive, active-low, one-hot-low
//   num_edit   [23:0] live entry value for the display path
//   num_out    [23:0] committed value (tuning word for the DDS core)
//   commit            one-cycle pulse when num_out updates
//   key_strobe        one-cycle pulse per accepted key
//   key_code   [3:0]  code of the last accepted key
//
// Modports:
//   master : the keypad_entry block (reads row, drives everything else)
//   slave  : the keypad / consumer side
// -----------------------------------------------------------------------------
interface keypad_entry_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [23:0] num_edit;
  logic [23:0] num_out;
  logic        commit;
  logic        key_strobe;
  logic [3:0]  key_code;

  modport master (
    input  row,
    output col,
    output num_edit,
    output num_out,
    output commit,
    output key_strobe,
    output key_code
  );

  modport slave (
    output row,
    input  col,
    input  num_edit,
    input  num_out,
    input  commit,
    input  key_strobe,
    input  key_code
  );
endinterface : keypad_entry_if

// File: rtl/keypad_entry.sv
// -----------------------------------------------------------------------------
// keypad_entry
//
// Scans a 4x4 active-low matrix keypad, debounces presses and releases, and
// assembles up to six hex digits into a 24-bit entry value. Key E clears the
// entry, key F commits it to num_out.
//
// Parameters:
//   SCAN_DIV      clock cycles per column slot (>= 4)
//   DEBOUNCE_CNT  consecutive identical samples to accept a press/release (>= 2)
//
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   kp       keypad_entry_if.master: row in, col / num_edit / num_out /
//            commit / key_strobe / key_code out
//
// Build option:
//   KEYPAD_BCD_EN  when defined, keys A-D are ignored (no shift, no strobe) so
//                  the entry always holds six BCD digits. When undefined,
//                  A-D shift in as hex digits.
// -----------------------------------------------------------------------------
module keypad_entry #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  keypad_entry_if.master kp
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_ACT,
    ST_HELD
  } state_e;

  // ---------------------------------------------------------------------------
  // Row synchronizer (rows are idle-high, so reset to all ones)
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta_q;
  logic [3:0] row_sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot timer: free-running, the last cycle of each slot is the sample point
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_cnt_q;
  logic              tick;

  assign tick = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_q <= '0;
    end else if (tick) begin
      slot_cnt_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic [1:0]       col_idx_q,     col_idx_d;
  logic [3:0]       pat_q,         pat_d;
  logic [DEB_W-1:0] deb_cnt_q,     deb_cnt_d;
  logic [23:0]      num_edit_q,    num_edit_d;
  logic [23:0]      num_out_q,     num_out_d;
  logic [2:0]       digit_cnt_q,   digit_cnt_d;
  logic             post_commit_q, post_commit_d;
  logic             commit_q,      commit_d;
  logic             key_strobe_q,  key_strobe_d;
  logic [3:0]       key_code_q,    key_code_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_SCAN;
      col_idx_q     <= 2'd0;
      pat_q         <= 4'hF;
      deb_cnt_q     <= '0;
      num_edit_q    <= 24'h0;
      num_out_q     <= 24'h0;
      digit_cnt_q   <= 3'd0;
      post_commit_q <= 1'b0;
      commit_q      <= 1'b0;
      key_strobe_q  <= 1'b0;
      key_code_q    <= 4'h0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      pat_q         <= pat_d;
      deb_cnt_q     <= deb_cnt_d;
      num_edit_q    <= num_edit_d;
      num_out_q     <= num_out_d;
      digit_cnt_q   <= digit_cnt_d;
      post_commit_q <= post_commit_d;
      commit_q      <= commit_d;
      key_strobe_q  <= key_strobe_d;
      key_code_q    <= key_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Key decode from the recorded row pattern and the frozen column.
  // With several rows low the lowest row index wins.
  // ---------------------------------------------------------------------------
  logic [1:0] row_idx;
  logic [3:0] act_code;
  logic       is_clear;
  logic       is_enter;
  logic       is_digit;

  always_comb begin
    row_idx = 2'd3;
    if (!pat_q[0]) begin
      row_idx = 2'd0;
    end else if (!pat_q[1]) begin
      row_idx = 2'd1;
    end else if (!pat_q[2]) begin
      row_idx = 2'd2;
    end
  end

  always_comb begin
    act_code = 4'h0;
    case ({row_idx, col_idx_q})
      4'b00_00: act_code = 4'h1;
      4'b00_01: act_code = 4'h2;
      4'b00_10: act_code = 4'h3;
      4'b00_11: act_code = 4'hA;
      4'b01_00: act_code = 4'h4;
      4'b01_01: act_code = 4'h5;
      4'b01_10: act_code = 4'h6;
      4'b01_11: act_code = 4'hB;
      4'b10_00: act_code = 4'h7;
      4'b10_01: act_code = 4'h8;
      4'b10_10: act_code = 4'h9;
      4'b10_11: act_code = 4'hC;
      4'b11_00: act_code = 4'hE;
      4'b11_01: act_code = 4'h0;
      4'b11_10: act_code = 4'hF;
      4'b11_11: act_code = 4'hD;
      default:  act_code = 4'h0;
    endcase
  end

  assign is_clear = (act_code == 4'hE);
  assign is_enter = (act_code == 4'hF);
`ifdef KEYPAD_BCD_EN
  assign is_digit = (act_code <= 4'h9);
`else
  assign is_digit = (act_code <= 4'hD);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and key action logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    pat_d         = pat_q;
    deb_cnt_d     = deb_cnt_q;
    num_edit_d    = num_edit_q;
    num_out_d     = num_out_q;
    digit_cnt_d   = digit_cnt_q;
    post_commit_d = post_commit_q;
    commit_d      = 1'b0;
    key_strobe_d  = 1'b0;
    key_code_d    = key_code_q;

    case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (row_sync_q != 4'hF) begin
            // This sample is the first of the debounce run.
            state_d   = ST_DEB_PRESS;
            pat_d     = row_sync_q;
            deb_cnt_d = DEB_W'(1);
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      ST_DEB_PRESS: begin
        if (tick) begin
          if (row_sync_q == pat_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
              state_d   = ST_ACT;
              deb_cnt_d = '0;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            state_d   = ST_SCAN;
            deb_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      ST_ACT: begin
        state_d   = ST_HELD;
        deb_cnt_d = '0;
        if (is_clear) begin
          num_edit_d    = 24'h0;
          digit_cnt_d   = 3'd0;
          post_commit_d = 1'b0;
          key_strobe_d  = 1'b1;
          key_code_d    = act_code;
        end else if (is_enter) begin
          num_out_d     = num_edit_q;
          commit_d      = 1'b1;
          digit_cnt_d   = 3'd0;
          post_commit_d = 1'b1;
          key_strobe_d  = 1'b1;
          key_code_d    = act_code;
        end else if (is_digit) begin
          key_strobe_d = 1'b1;
          key_code_d   = act_code;
          if (post_commit_q) begin
            // The committed value stays on display until the next digit,
            // which then starts a fresh entry instead of shifting.
            num_edit_d    = {20'h0, act_code};
            digit_cnt_d   = 3'd1;
            post_commit_d = 1'b0;
          end else if (digit_cnt_q < 3'd6) begin
            num_edit_d  = {num_edit_q[19:0], act_code};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end
      end

      ST_HELD: begin
        if (tick) begin
          if (row_sync_q == 4'hF) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
              state_d   = ST_SCAN;
              deb_cnt_d = '0;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            // Bounce while held only restarts the release count.
            deb_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign kp.col        = ~(4'b0001 << col_idx_q);
  assign kp.num_edit   = num_edit_q;
  assign kp.num_out    = num_out_q;
  assign kp.commit     = commit_q;
  assign kp.key_strobe = key_strobe_q;
  assign kp.key_code   = key_code_q;

endmodule : keypad_entry

// File: tb/tb_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry
//
// Directed bench for keypad_entry with SCAN_DIV = 4, DEBOUNCE_CNT = 3.
// A small keypad model pulls the pressed key's row low while its column is
// driven; a force mode drives raw row patterns for the debounce scenario.
// -----------------------------------------------------------------------------
module tb_keypad_entry;

  logic clock;
  logic reset_n;

  keypad_entry_if kif ();

  keypad_entry #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .kp      (kif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad model
  logic       press_en;
  int         press_r;
  int         press_c;
  logic       force_mode;
  logic [3:0] force_row;

  always_comb begin
    kif.row = 4'hF;
    if (force_mode) begin
      kif.row = force_row;
    end else if (press_en && (kif.col[press_c] == 1'b0)) begin
      kif.row[press_r] = 1'b0;
    end
  end

  // Pulse monitors
  int strobe_cnt;
  int commit_cnt;
  int commit_alone_cnt;

  initial begin
    strobe_cnt       = 0;
    commit_cnt       = 0;
    commit_alone_cnt = 0;
  end

  always @(posedge clock) begin
    if (kif.key_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
    if (kif.commit === 1'b1) begin
      commit_cnt = commit_cnt + 1;
      if (kif.key_strobe !== 1'b1) commit_alone_cnt = commit_alone_cnt + 1;
    end
  end

  int tests_run;
  int tests_failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold a key for 20 slots, then release and let the block return to SCAN.
  task automatic press_key(input int r, input int c);
    press_r  = r;
    press_c  = c;
    press_en = 1'b1;
    cycles(80);
    press_en = 1'b0;
    cycles(40);
  endtask

  int dig_r [7] = '{0, 0, 0, 1, 1, 1, 2};
  int dig_c [7] = '{0, 1, 2, 0, 1, 2, 0};
  int s0;
  logic [3:0] c0;
  logic [3:0] c_rot;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    press_en     = 1'b0;
    press_r      = 0;
    press_c      = 0;
    force_mode   = 1'b0;
    force_row    = 4'hF;

    // ---------------- Reset ----------------
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_col",        {28'h0, kif.col},        32'h0000000E);
    check("rst_num_edit",   {8'h0, kif.num_edit},    32'h0);
    check("rst_num_out",    {8'h0, kif.num_out},     32'h0);
    check("rst_commit",     {31'h0, kif.commit},     32'h0);
    check("rst_key_strobe", {31'h0, kif.key_strobe}, 32'h0);
    check("rst_key_code",   {28'h0, kif.key_code},   32'h0);
    cycles(3);
    check("col_after_3",  {28'h0, kif.col}, 32'hE);
    cycles(1);
    check("col_after_4",  {28'h0, kif.col}, 32'hD);
    cycles(11);
    check("col_after_15", {28'h0, kif.col}, 32'h7);
    cycles(1);
    check("col_after_16", {28'h0, kif.col}, 32'hE);

    // ---------------- Entry and commit ----------------
    press_key(0, 0);
    press_key(0, 1);
    press_key(0, 2);
    check("entry_123",      {8'h0, kif.num_edit},  32'h000123);
    check("entry_code3",    {28'h0, kif.key_code}, 32'h3);
    check("entry_strobes",  strobe_cnt,            32'd3);
    press_key(3, 2);
    check("commit_count",   commit_cnt,            32'd1);
    check("commit_num_out", {8'h0, kif.num_out},   32'h000123);
    check("commit_keep",    {8'h0, kif.num_edit},  32'h000123);
    check("commit_code",    {28'h0, kif.key_code}, 32'hF);
    press_key(1, 1);
    check("post_commit_5",  {8'h0, kif.num_edit},  32'h000005);
    check("post_commit_out",{8'h0, kif.num_out},   32'h000123);

    // ---------------- Debounce reject ----------------
    s0         = strobe_cnt;
    force_row  = 4'b1101;
    force_mode = 1'b1;
    cycles(8);
    force_row  = 4'hF;
    cycles(4);
    force_row  = 4'b1101;
    cycles(4);
    force_row  = 4'hF;
    cycles(20);
    force_mode = 1'b0;
    check("reject_no_strobe", strobe_cnt - s0, 32'd0);
    c0    = kif.col;
    c_rot = {c0[2:0], c0[3]};
    cycles(4);
    check("reject_scan_resumes", {28'h0, kif.col}, {28'h0, c_rot});

    // ---------------- Overflow and clear ----------------
    press_key(3, 0);
    check("clear_before", {8'h0, kif.num_edit}, 32'h0);
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) press_key(dig_r[i], dig_c[i]);
    check("six_digits",   {8'h0, kif.num_edit},  32'h123456);
    press_key(dig_r[6], dig_c[6]);
    check("seventh_ignored", {8'h0, kif.num_edit}, 32'h123456);
    check("seventh_code",    {28'h0, kif.key_code}, 32'h7);
    check("seventh_strobes", strobe_cnt - s0,       32'd7);
    press_key(3, 0);
    check("clear_num_edit",  {8'h0, kif.num_edit},  32'h0);
    check("clear_num_out",   {8'h0, kif.num_out},   32'h000123);
    check("clear_no_commit", commit_cnt,            32'd1);

    // ---------------- Hex key per build ----------------
    s0 = strobe_cnt;
    press_key(0, 3);
`ifdef KEYPAD_BCD_EN
    check("keyA_num_edit", {8'h0, kif.num_edit},  32'h0);
    check("keyA_strobes",  strobe_cnt - s0,       32'd0);
    check("keyA_code",     {28'h0, kif.key_code}, 32'hE);
`else
    check("keyA_num_edit", {8'h0, kif.num_edit},  32'h00000A);
    check("keyA_strobes",  strobe_cnt - s0,       32'd1);
    check("keyA_code",     {28'h0, kif.key_code}, 32'hA);
`endif
    press_key(3, 0);

    // ---------------- Reset during HELD ----------------
    press_r  = 2;
    press_c  = 2;
    press_en = 1'b1;
    cycles(60);
    check("held_num_edit", {8'h0, kif.num_edit}, 32'h000009);
    reset_n = 1'b0;
    #1;
    check("mid_rst_num_edit", {8'h0, kif.num_edit},  32'h0);
    check("mid_rst_num_out",  {8'h0, kif.num_out},   32'h0);
    check("mid_rst_key_code", {28'h0, kif.key_code}, 32'h0);
    check("mid_rst_col",      {28'h0, kif.col},      32'hE);
    cycles(2);
    @(negedge clock);
    reset_n = 1'b1;
    s0 = strobe_cnt;
    cycles(80);
    check("rehold_strobes",  strobe_cnt - s0,       32'd1);
    check("rehold_code",     {28'h0, kif.key_code}, 32'h9);
    check("rehold_num_edit", {8'h0, kif.num_edit},  32'h000009);
    press_en = 1'b0;
    cycles(40);
    check("release_strobes", strobe_cnt - s0,       32'd1);

    check("commit_with_strobe", commit_alone_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_keypad_entry
